// File: rtl/pipe_ex.sv
// Execute stage: ID/EX pipeline register, operand select with
// MEM/WB forwarding, and the 32-bit ALU.
package pipe_ex_pkg;
  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic [1:0]  sela;
    logic [1:0]  selb;
    logic [4:0]  wn;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
  } id_ex_t;
endpackage

module pipe_ex
  import pipe_ex_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        IDwreg,
  input  logic        IDm2reg,
  input  logic        IDwmem,
  input  logic [3:0]  IDaluc,
  input  logic [1:0]  IDselectAlua,
  input  logic [1:0]  IDselectAlub,
  input  logic [4:0]  IDwn,
  input  logic [31:0] IDqa,
  input  logic [31:0] IDqb,
  input  logic [31:0] IDsaOrImme,
  input  logic [31:0] MEMalu,
  input  logic [31:0] WBdata,
  output logic        EXwreg,
  output logic        EXm2reg,
  output logic        EXwmem,
  output logic [4:0]  EXwn,
  output logic [31:0] EXalu,
  output logic [31:0] EXstore,
  output logic        EXzero
);

  id_ex_t ex_q, ex_d;
  logic [31:0] a, b, alu;

  always_comb begin
    ex_d       = '0;
    ex_d.wreg  = IDwreg;
    ex_d.m2reg = IDm2reg;
    ex_d.wmem  = IDwmem;
    ex_d.aluc  = IDaluc;
    ex_d.sela  = IDselectAlua;
    ex_d.selb  = IDselectAlub;
    ex_d.wn    = IDwn;
    ex_d.qa    = IDqa;
    ex_d.qb    = IDqb;
    ex_d.imm   = IDsaOrImme;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  always_comb begin
    a = ex_q.qa;
    case (ex_q.sela)
      2'b01:   a = MEMalu;
      2'b10:   a = WBdata;
      2'b11:   a = ex_q.imm;
      default: a = ex_q.qa;
    endcase
  end

  always_comb begin
    b = ex_q.qb;
    case (ex_q.selb)
      2'b01:   b = MEMalu;
      2'b10:   b = WBdata;
      2'b11:   b = ex_q.imm;
      default: b = ex_q.qb;
    endcase
  end

  // Shifts take the amount from a[4:0] and shift b.
  always_comb begin
    alu = '0;
    case (ex_q.aluc)
      4'h0:    alu = a + b;
      4'h1:    alu = a - b;
      4'h2:    alu = a & b;
      4'h3:    alu = a | b;
      4'h4:    alu = a ^ b;
      4'h5:    alu = ~(a | b);
      4'h6:    alu = b << a[4:0];
      4'h7:    alu = b >> a[4:0];
      4'h8:    alu = $unsigned($signed(b) >>> a[4:0]);
      4'h9:    alu = {31'd0, $signed(a) < $signed(b)};
      4'hA:    alu = {31'd0, a < b};
      4'hB:    alu = {b[15:0], 16'h0000};
      default: alu = '0;
    endcase
  end

  assign EXwreg  = ex_q.wreg;
  assign EXm2reg = ex_q.m2reg;
  assign EXwmem  = ex_q.wmem;
  assign EXwn    = ex_q.wn;
  assign EXalu   = alu;
  assign EXstore = ex_q.qb;
  assign EXzero  = (alu == 32'd0);

endmodule

// File: tb/tb_pipe_ex.sv
// Directed bench for pipe_ex with a behavioural reference model
// checked every cycle, plus literal expectations.
module tb_pipe_ex;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        IDwreg = 0, IDm2reg = 0, IDwmem = 0;
  logic [3:0]  IDaluc = 0;
  logic [1:0]  IDselectAlua = 0, IDselectAlub = 0;
  logic [4:0]  IDwn = 0;
  logic [31:0] IDqa = 0, IDqb = 0, IDsaOrImme = 0;
  logic [31:0] MEMalu = 0, WBdata = 0;
  logic        EXwreg, EXm2reg, EXwmem, EXzero;
  logic [4:0]  EXwn;
  logic [31:0] EXalu, EXstore;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  typedef struct {
    logic        wreg, m2reg, wmem;
    logic [3:0]  op;
    logic [1:0]  sa, sb;
    logic [4:0]  wn;
    logic [31:0] qa, qb, imm;
  } mdl_t;

  mdl_t m;

  pipe_ex dut (
    .clk(clk), .clrn(clrn),
    .IDwreg(IDwreg), .IDm2reg(IDm2reg), .IDwmem(IDwmem),
    .IDaluc(IDaluc),
    .IDselectAlua(IDselectAlua), .IDselectAlub(IDselectAlub),
    .IDwn(IDwn), .IDqa(IDqa), .IDqb(IDqb),
    .IDsaOrImme(IDsaOrImme), .MEMalu(MEMalu), .WBdata(WBdata),
    .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem),
    .EXwn(EXwn), .EXalu(EXalu), .EXstore(EXstore),
    .EXzero(EXzero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pick(
    input logic [1:0] s, input logic [31:0] q,
    input logic [31:0] imm);
    if (s == 2'd1) return MEMalu;
    if (s == 2'd2) return WBdata;
    if (s == 2'd3) return imm;
    return q;
  endfunction

  function automatic logic [31:0] ref_alu(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b);
    int sh;
    sh = int'(a % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return b << sh;
      4'd7:  return b >> sh;
      4'd8:  return b[31] ? ~((~b) >> sh) : (b >> sh);
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd11: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    logic [31:0] ea, eb, ey;
    ea = pick(m.sa, m.qa, m.imm);
    eb = pick(m.sb, m.qb, m.imm);
    ey = ref_alu(m.op, ea, eb);
    chk({tag, ".wreg"},  {31'd0, EXwreg},  {31'd0, m.wreg});
    chk({tag, ".m2reg"}, {31'd0, EXm2reg}, {31'd0, m.m2reg});
    chk({tag, ".wmem"},  {31'd0, EXwmem},  {31'd0, m.wmem});
    chk({tag, ".wn"},    {27'd0, EXwn},    {27'd0, m.wn});
    chk({tag, ".alu"},   EXalu, ey);
    chk({tag, ".store"}, EXstore, m.qb);
    chk({tag, ".zero"},  {31'd0, EXzero},
        {31'd0, ey == 32'd0});
  endtask

  always @(negedge clk) if (run) model_check("cyc");

  task automatic tick();
    mdl_t nxt;
    nxt = '{IDwreg, IDm2reg, IDwmem, IDaluc, IDselectAlua,
            IDselectAlub, IDwn, IDqa, IDqb, IDsaOrImme};
    @(posedge clk);
    if (clrn) m = nxt;
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] op,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic [4:0] wn, input logic [31:0] qa,
                       input logic [31:0] qb, input logic [31:0] im);
    IDwreg = w; IDm2reg = 0; IDwmem = 0; IDaluc = op;
    IDselectAlua = sa; IDselectAlub = sb; IDwn = wn;
    IDqa = qa; IDqb = qb; IDsaOrImme = im;
  endtask

  task automatic chk_zero_state(input string nm);
    chk({nm, ".wreg"}, {31'd0, EXwreg}, 32'd0);
    chk({nm, ".wmem"}, {31'd0, EXwmem}, 32'd0);
    chk({nm, ".m2reg"}, {31'd0, EXm2reg}, 32'd0);
    chk({nm, ".wn"}, {27'd0, EXwn}, 32'd0);
    chk({nm, ".store"}, EXstore, 32'd0);
    chk({nm, ".alu"}, EXalu, 32'd0);
    chk({nm, ".zero"}, {31'd0, EXzero}, 32'd1);
  endtask

  initial begin
    m = '{0, 0, 0, 4'd0, 2'd0, 2'd0, 5'd0, 0, 0, 0};
    #2 clrn = 1'b0;
    #1 chk_zero_state("rst0");
    run = 1;
    tick();
    #2 clrn = 1'b1;
    #1;

    drive(1, 4'h0, 2'd0, 2'd0, 5'd7, 32'd5, 32'd3, 32'd0);
    tick();
    chk("add", EXalu, 32'd8);
    chk("add.wn", {27'd0, EXwn}, 32'd7);
    chk("add.wreg", {31'd0, EXwreg}, 32'd1);
    drive(1, 4'h1, 2'd0, 2'd0, 5'd9, 32'd5, 32'd3, 32'd0);
    tick();
    chk("sub", EXalu, 32'd2);
    chk("sub.wn", {27'd0, EXwn}, 32'd9);

    MEMalu = 32'h10; WBdata = 32'h20;
    drive(1, 4'h0, 2'd1, 2'd2, 5'd3, 32'd1, 32'd2, 32'd0);
    tick();
    chk("fwd", EXalu, 32'h30);
    MEMalu = 32'h0;
    #1 chk("fwd.mem0", EXalu, 32'h20);

    drive(1, 4'h7, 2'd3, 2'd0, 5'd4, 32'd0, 32'h8000_0000, 32'd4);
    tick();
    chk("srl", EXalu, 32'h0800_0000);
    drive(1, 4'h8, 2'd3, 2'd0, 5'd4, 32'd0, 32'h8000_0000, 32'd4);
    tick();
    chk("sra", EXalu, 32'hF800_0000);
    drive(1, 4'h7, 2'd3, 2'd0, 5'd4, 32'd0, 32'h8000_0000, 32'd36);
    tick();
    chk("srl36", EXalu, 32'h0800_0000);

    drive(1, 4'h9, 2'd0, 2'd0, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    chk("slt", EXalu, 32'd1);
    drive(1, 4'hA, 2'd0, 2'd0, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    chk("sltu", EXalu, 32'd0);
    chk("sltu.z", {31'd0, EXzero}, 32'd1);
    drive(1, 4'hB, 2'd0, 2'd3, 5'd6, 32'd9, 32'd1, 32'h1234);
    tick();
    chk("lui", EXalu, 32'h1234_0000);

    drive(1, 4'h2, 2'd0, 2'd0, 5'd8, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0);
    tick();
    chk("and", EXalu, 32'h00F0_000F);
    IDaluc = 4'h3; tick();
    chk("or", EXalu, 32'hFFF0_0FFF);
    IDaluc = 4'h4; tick();
    chk("xor", EXalu, 32'hFF00_0FF0);
    IDaluc = 4'h5; tick();
    chk("nor", EXalu, 32'h000F_F000);
    IDaluc = 4'hC; tick();
    chk("op12", EXalu, 32'd0);
    IDaluc = 4'hF; tick();
    chk("op15", EXalu, 32'd0);
    drive(1, 4'h6, 2'd3, 2'd0, 5'd8, 32'd0, 32'h0000_00FF, 32'd8);
    tick();
    chk("sll", EXalu, 32'h0000_FF00);
    drive(1, 4'h1, 2'd0, 2'd0, 5'd8, 32'd0, 32'd1, 32'd0);
    tick();
    chk("subwrap", EXalu, 32'hFFFF_FFFF);

    drive(0, 4'h1, 2'd0, 2'd0, 5'd2, 32'd7, 32'd7, 32'd0);
    tick();
    chk("bub.wreg", {31'd0, EXwreg}, 32'd0);
    chk("bub.wmem", {31'd0, EXwmem}, 32'd0);
    chk("bub.alu", EXalu, 32'd0);
    chk("bub.zero", {31'd0, EXzero}, 32'd1);
    chk("bub.store", EXstore, 32'd7);

    drive(1, 4'h0, 2'd0, 2'd0, 5'd31, 32'd1, 32'hAB, 32'd0);
    IDm2reg = 1; IDwmem = 1;
    tick();
    chk("st.store", EXstore, 32'hAB);
    chk("st.m2reg", {31'd0, EXm2reg}, 32'd1);
    #2 clrn = 1'b0;
    m = '{0, 0, 0, 4'd0, 2'd0, 2'd0, 5'd0, 0, 0, 0};
    #1 chk_zero_state("rstmid");
    repeat (3) tick();
    chk_zero_state("rsthold");
    #2 clrn = 1'b1;
    #1 chk_zero_state("rstrel");
    tick();
    chk("rel.store", EXstore, 32'hAB);
    chk("rel.wn", {27'd0, EXwn}, 32'd31);
    chk("rel.alu", EXalu, 32'hAC);

    @(negedge clk);
    #1 run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
